// File: rtl/yfilt_pkg.sv
// Shared widths and helpers for the y-filter datapath (filt_yVal and ex_cmplx_mac).
package yfilt_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned YENT_W = 48;
  localparam int unsigned ACC_W  = 52;
  localparam int unsigned FRAC_W = 23;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } macState_e;

  // Rescale a Q-format accumulator back to Q1.23, clamping on overflow.
  function automatic logic [DATA_W-1:0] satShift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0]      sh;
    logic [ACC_W-DATA_W:0]        upper;
    sh    = acc >>> FRAC_W;
    upper = sh[ACC_W-1:DATA_W-1];
    if (upper == '0 || upper == '1)
      return sh[DATA_W-1:0];
    else if (sh[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/ex_cmplx_mac_mul24s.sv
// Registered signed 24x24 -> 48 multiplier used by the complex MAC.
module mul24s
  import yfilt_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [YENT_W-1:0] p
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      p <= '0;
    else
      p <= YENT_W'(a) * YENT_W'(b);
  end

endmodule

// File: rtl/ex_cmplx_mac.sv
// Complex multiply-accumulate of a change value against two y entries, one real
// multiply per cycle, with saturated Q1.23 results and a one-cycle done pulse.
module ex_cmplx_mac
  import yfilt_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_EN,
  input  logic              acc_clr,
  input  logic [DATA_W-1:0] chng_real,
  input  logic [DATA_W-1:0] chng_img,
  input  logic [YENT_W-1:0] yVal1,
  input  logic [YENT_W-1:0] yVal2,
  output logic              op_exModDone,
  output logic              op_busy,
  output logic [DATA_W-1:0] op_real,
  output logic [DATA_W-1:0] op_img
);

  macState_e                state;
  logic [2:0]               k;
  logic signed [DATA_W-1:0] cr, ci;
  logic [YENT_W-1:0]        y1, y2;
  logic signed [ACC_W-1:0]  accRe, accIm;
  logic signed [ACC_W-1:0]  accReNext, accImNext, term;
  logic                     prodVld;
  logic [1:0]               prodSel;
  logic signed [DATA_W-1:0] mulA, mulB, yr, yi;
  logic signed [YENT_W-1:0] product;

  // k[2] picks the y entry; k[1:0] walks cr*yr, ci*yi, cr*yi, ci*yr.
  always_comb begin
    yr   = k[2] ? y2[YENT_W-1:DATA_W] : y1[YENT_W-1:DATA_W];
    yi   = k[2] ? y2[DATA_W-1:0]      : y1[DATA_W-1:0];
    mulA = k[0] ? ci : cr;
    mulB = (k[0] ^ k[1]) ? yi : yr;
  end

  mul24s uMul (
    .clock (clock),
    .reset (reset),
    .a     (mulA),
    .b     (mulB),
    .p     (product)
  );

  // Products arrive one cycle after issue, so the last term is folded in
  // combinationally while in DONE to meet the fixed 9-edge latency.
  always_comb begin
    term      = ACC_W'(product);
    accReNext = accRe;
    accImNext = accIm;
    if (prodVld) begin
      case (prodSel)
        2'd0:    accReNext = accRe + term;
        2'd1:    accReNext = accRe - term;
        default: accImNext = accIm + term;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      cr           <= '0;
      ci           <= '0;
      y1           <= '0;
      y2           <= '0;
      accRe        <= '0;
      accIm        <= '0;
      prodVld      <= 1'b0;
      prodSel      <= '0;
      op_exModDone <= 1'b0;
      op_busy      <= 1'b0;
      op_real      <= '0;
      op_img       <= '0;
    end else begin
      op_exModDone <= 1'b0;
      prodVld      <= (state == MUL);
      prodSel      <= k[1:0];
      accRe        <= accReNext;
      accIm        <= accImNext;
      case (state)
        IDLE: begin
          if (acc_clr) begin
            accRe <= '0;
            accIm <= '0;
          end
          if (ex_EN) begin
            cr      <= chng_real;
            ci      <= chng_img;
            y1      <= yVal1;
            y2      <= yVal2;
            k       <= '0;
            op_busy <= 1'b1;
            state   <= MUL;
          end
        end
        MUL: begin
          k <= k + 3'd1;
          if (k == 3'd7)
            state <= DONE;
        end
        DONE: begin
          op_real      <= satShift(accReNext);
          op_img       <= satShift(accImNext);
          op_exModDone <= 1'b1;
          op_busy      <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_cmplx_mac.md
EX_CMPLX_MAC -- requirements
Module: ex_cmplx_mac

Interface
REQ-001 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port ex_EN  in  1  start pulse, driven by filt_yVal op_EX_EN.
REQ-004 SHALL have port acc_clr  in  1  clear accumulators at start of a new change row.
REQ-005 SHALL have port chng_real  in  24  signed Q1.23 real part of change value.
REQ-006 SHALL have port chng_img  in  24  signed Q1.23 imaginary part of change value.
REQ-007 SHALL have port yVal1  in  48  {real[47:24], imag[23:0]}, signed Q1.23, driven by op_yVal1.
REQ-008 SHALL have port yVal2  in  48  same format as yVal1, driven by op_yVal2.
REQ-009 SHALL have port op_exModDone  out  1  one-cycle completion pulse, drives filt_yVal exModDone.
REQ-010 SHALL have port op_busy  out  1  high from the cycle after ex_EN is accepted until op_exModDone is high.
REQ-011 SHALL have port op_real  out  24  saturated real accumulator result, Q1.23.
REQ-012 SHALL have port op_img  out  24  saturated imaginary accumulator result, Q1.23.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DONE; IDLE->MUL on ex_EN; MUL->DONE when step counter = 7; DONE->IDLE unconditionally.
REQ-014 SHALL, on the edge that samples ex_EN in IDLE, register chng_real, chng_img, yVal1, yVal2 and clear 3-bit step counter k.
REQ-015 SHALL in MUL perform one signed 24x24 multiply per cycle on registered operands; k increments each cycle.
REQ-016 SHALL use product order k=0 +cr*yr1 to real; k=1 -ci*yi1 to real; k=2 +cr*yi1 to imag; k=3 +ci*yr1 to imag; k=4..7 same for yVal2.
REQ-017 SHALL accumulate full 48-bit products into 52-bit signed real/imag accumulators; no intermediate truncation.
REQ-018 SHALL in DONE load op_real/op_img with accumulator arithmetic-shifted right 23 (truncate toward minus infinity), saturated to 0x7FFFFF / 0x800000.
REQ-019 SHALL raise op_exModDone for exactly one cycle, 9 rising edges after the edge that sampled ex_EN; op_real/op_img valid in that same cycle and held until next DONE.
REQ-020 SHALL keep accumulators across operations; results represent running sum since last clear.
REQ-021 SHALL honour acc_clr only in IDLE; acc_clr and ex_EN in the same cycle: clear first, then this operation accumulates from zero.
REQ-022 SHALL ignore ex_EN and acc_clr while in MUL or DONE (no queuing; upstream waits for op_exModDone).
REQ-023 SHALL leave op_real/op_img unchanged by acc_clr; they update only in DONE.

Reset
REQ-024 SHALL on reset asynchronously force state IDLE, k=0, accumulators 0, operand registers 0, op_exModDone=0, op_busy=0, op_real=0, op_img=0.
REQ-025 SHALL on reset mid-MUL abandon the operation with no op_exModDone pulse; next ex_EN after release starts cleanly.

Structure
REQ-026 SHALL take data width 24, y-entry width 48, accumulator width 52 and fraction bits 23 from shared package yfilt_pkg, also used by filt_yVal.
REQ-027 SHALL instantiate one sub-module mul24s: registered signed 24x24->48 multiplier; the pipeline delay is absorbed inside the 9-edge latency.
REQ-028 SHALL fit 120-400 lines of RTL excluding the package.

Verification
REQ-029 SHALL cover: acc_clr+ex_EN, chng=0x400000+j0, yVal1={0x400000,0x200000}, yVal2=0 -> 9 edges later op_exModDone pulse, op_real=0x200000, op_img=0x100000.
REQ-030 SHALL cover: repeat same ex_EN without acc_clr -> op_real=0x400000, op_img=0x200000 (accumulation).
REQ-031 SHALL cover: acc_clr+ex_EN, chng=0+j0x400000, yVal1={0,0x400000}, yVal2=0 -> op_real=0xE00000, op_img=0x000000 (sign of ci*yi term).
REQ-032 SHALL cover: acc_clr+ex_EN, chng=0x7FFFFF, yVal1=yVal2={0x7FFFFF,0} -> op_real=0x7FFFFF saturated, op_img=0.
REQ-033 SHALL cover: ex_EN re-pulsed at k=3 -> ignored, single op_exModDone; reset asserted at k=5 -> no op_exModDone, all outputs 0, next operation correct.
REQ-034 SHALL cover: full chain with filt_yVal -> op_exModDone drives exModDone, op_busy never overlaps a second op_EX_EN.
